// File: rtl/ccff_bitstream_loader.sv
// Configuration-chain head driver: serialises valid/ready bitstream words LSB first onto ccff_head.
// Define CCFF_VERIFY_EN to prepend a MARKER preamble and check it as it leaves through ccff_tail.
module ccff_bitstream_loader #(
  parameter int unsigned         WORD_W    = 32,
  parameter int unsigned         CHAIN_LEN = 1024,
  parameter int unsigned         CNT_W     = 16,
  parameter int unsigned         MARKER_W  = 8,
  parameter logic [MARKER_W-1:0] MARKER    = 8'hA5
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              verify_fail
);

`ifdef CCFF_VERIFY_EN
  localparam int unsigned N = CHAIN_LEN + MARKER_W;
`else
  localparam int unsigned N = CHAIN_LEN;
`endif
  localparam logic [CNT_W-1:0] N_C      = CNT_W'(N);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_FETCH, S_SHIFT, S_FIN} state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  bit_q;
  logic [WORD_W-1:0] word_q;
  logic              head_q;
  logic              shift_en_q;
  logic              ready_q;
  logic              busy_q;
  logic              done_q;
  logic [CNT_W-1:0]  cnt_d;

  assign cnt_d = cnt_q + CNT_W'(1);

`ifdef CCFF_VERIFY_EN
  localparam logic [CNT_W-1:0] MK_LAST = CNT_W'(MARKER_W - 1);
  logic [MARKER_W-1:0] mk_q;
`endif

  // head/shift_en are loaded for the cycle they will be seen in; the word is consumed by right shifts
  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      word_q     <= '0;
      head_q     <= 1'b0;
      shift_en_q <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef CCFF_VERIFY_EN
      mk_q       <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            cnt_q  <= '0;
            busy_q <= 1'b1;
`ifdef CCFF_VERIFY_EN
            state_q    <= S_PRE;
            shift_en_q <= 1'b1;
            head_q     <= MARKER[0];
            mk_q       <= MARKER >> 1;
`else
            state_q <= S_FETCH;
            ready_q <= 1'b1;
`endif
          end
        end
`ifdef CCFF_VERIFY_EN
        S_PRE: begin
          cnt_q <= cnt_d;
          if (cnt_q == MK_LAST) begin
            state_q    <= S_FETCH;
            shift_en_q <= 1'b0;
            ready_q    <= 1'b1;
          end else begin
            head_q <= mk_q[0];
            mk_q   <= mk_q >> 1;
          end
        end
`endif
        S_FETCH: begin
          if (word_valid) begin
            state_q    <= S_SHIFT;
            word_q     <= word_in >> 1;
            head_q     <= word_in[0];
            shift_en_q <= 1'b1;
            ready_q    <= 1'b0;
            bit_q      <= '0;
          end
        end
        S_SHIFT: begin
          cnt_q <= cnt_d;
          if (cnt_d == N_C || bit_q == LAST_BIT) begin
            shift_en_q <= 1'b0;
            if (cnt_d == N_C) begin
              state_q <= S_FIN;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_FETCH;
              ready_q <= 1'b1;
            end
          end else begin
            bit_q  <= bit_q + CNT_W'(1);
            head_q <= word_q[0];
            word_q <= word_q >> 1;
          end
        end
        S_FIN: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef CCFF_VERIFY_EN
  // Once CHAIN_LEN edges have happened, the tail presents preamble bit (cnt - CHAIN_LEN)
  logic [CNT_W-1:0]    mk_idx;
  logic [MARKER_W-1:0] mk_sh;
  logic                in_win;
  logic                vf_q;

  assign mk_idx = cnt_q - CNT_W'(CHAIN_LEN);
  assign mk_sh  = MARKER >> mk_idx;
  assign in_win = (state_q != S_IDLE) && (cnt_q >= CNT_W'(CHAIN_LEN)) && (cnt_q < N_C);

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      vf_q <= 1'b0;
    end else if (state_q == S_IDLE && start) begin
      vf_q <= 1'b0;
    end else if (in_win && (ccff_tail != mk_sh[0])) begin
      vf_q <= 1'b1;
    end
  end

  assign verify_fail = vf_q;
`else
  logic unused_ok;
  assign unused_ok   = ^{ccff_tail, MARKER};
  assign verify_fail = 1'b0;
`endif

  assign word_ready    = ready_q;
  assign ccff_head     = head_q;
  assign ccff_shift_en = shift_en_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule
